// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port video RAM: video has priority, CPU gets a
// guaranteed slot after CPU_MAX_STALL lost contests; reads return via a 2-stage tag pipe.
module vram_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 8,
  parameter int CPU_MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] MAX_STALL = 4'(CPU_MAX_STALL);

  logic [3:0]        stall_q, stall_d;
  logic              stall_hit;
  logic              cpu_xfer, vid_xfer;
  // Tags are {valid, is_cpu, is_read}; tag0 is set on the transfer edge, tag1 one edge later.
  logic [2:0]        tag0_q, tag0_d, tag1_q;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, vid_data_q, vid_data_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, vid_valid_q, vid_valid_d;

  always_comb begin
    stall_hit   = (stall_q == MAX_STALL);
    cpu_gnt     = cpu_req & (~vid_req | stall_hit);
    vid_gnt     = vid_req & ~(cpu_req & stall_hit);
    cpu_xfer    = cpu_req & cpu_gnt;
    vid_xfer    = vid_req & vid_gnt;

    stall_d     = stall_q;
    if (!cpu_req || cpu_xfer) begin
      stall_d = 4'd0;
    end else if (vid_xfer && !stall_hit) begin
      stall_d = stall_q + 4'd1;
    end

    ram_en_d    = cpu_xfer | vid_xfer;
    ram_we_d    = cpu_xfer & cpu_we;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag0_d      = 3'b000;
    if (cpu_xfer) begin
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
      tag0_d      = {1'b1, 1'b1, ~cpu_we};
    end else if (vid_xfer) begin
      ram_addr_d  = vid_addr;
      tag0_d      = 3'b101;
    end

    // RAM data for the access tagged in tag1 is present now; capture it on this edge.
    cpu_rvalid_d = tag1_q[2] & tag1_q[1] & tag1_q[0];
    vid_valid_d  = tag1_q[2] & ~tag1_q[1] & tag1_q[0];
    cpu_rdata_d  = cpu_rvalid_d ? ram_rdata : cpu_rdata_q;
    vid_data_d   = vid_valid_d ? ram_rdata : vid_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q      <= 4'd0;
      tag0_q       <= 3'b000;
      tag1_q       <= 3'b000;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      vid_data_q   <= '0;
      vid_valid_q  <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag0_q;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_data_q   <= vid_data_d;
      vid_valid_q  <= vid_valid_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign vid_data   = vid_data_q;
  assign vid_valid  = vid_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 2048x8 synchronous RAM attached.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        vid_req = 1'b0;
  logic [10:0] vid_addr = '0;
  logic        vid_gnt, vid_valid;
  logic [7:0]  vid_data;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  mem [0:2047];

  int total = 0;
  int bad = 0;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({ram_en, ram_we, cpu_rvalid, vid_valid, cpu_gnt, vid_gnt} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {ram_en, ram_we, cpu_rvalid, vid_valid, cpu_gnt, vid_gnt});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ram_en, cpu_rvalid, vid_valid, cpu_gnt, vid_gnt} !== 5'b0) begin
      bad++; $display("FAIL idle_ctrl got=%b exp=00000", {ram_en, cpu_rvalid, vid_valid, cpu_gnt, vid_gnt});
    end
  endtask

  task automatic test_cpu_wr_rd();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'hA5;
    #1;
    total++;
    if ({cpu_gnt, vid_gnt} !== 2'b10) begin
      bad++; $display("FAIL wr_gnt got=%b exp=10", {cpu_gnt, vid_gnt});
    end
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 11'h123, 8'hA5}) begin
      bad++; $display("FAIL wr_issue got=%b/%b/%h/%h exp=1/1/123/a5", ram_en, ram_we, ram_addr, ram_wdata);
    end
    cpu_we = 1'b0;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL rd_gnt got=%b exp=1", cpu_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    total++;
    if ({ram_en, ram_we, ram_addr, cpu_rvalid} !== {1'b1, 1'b0, 11'h123, 1'b0}) begin
      bad++; $display("FAIL rd_issue got=%b/%b/%h/%b exp=1/0/123/0", ram_en, ram_we, ram_addr, cpu_rvalid);
    end
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr, cpu_rvalid} !== {1'b0, 1'b0, 11'h123, 1'b0}) begin
      bad++; $display("FAIL idle_hold got=%b/%b/%h/%b exp=0/0/123/0", ram_en, ram_we, ram_addr, cpu_rvalid);
    end
    @(negedge clk);
    total++;
    if ({cpu_rvalid, cpu_rdata, vid_valid} !== {1'b1, 8'hA5, 1'b0}) begin
      bad++; $display("FAIL rd_resp got=%b/%h/%b exp=1/a5/0", cpu_rvalid, cpu_rdata, vid_valid);
    end
    @(negedge clk);
    total++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'hA5}) begin
      bad++; $display("FAIL rd_hold got=%b/%h exp=0/a5", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'(i); cpu_wdata = 8'(i) ^ 8'h55;
      #1;
      total++;
      if ({cpu_gnt, cpu_rvalid} !== 2'b10) begin
        bad++; $display("FAIL preload_%0d got=%b exp=10", i, {cpu_gnt, cpu_rvalid});
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_vid_stream();
    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      total++;
      if (n >= 3 && n < 19) begin
        if ({vid_valid, vid_data, cpu_rvalid} !== {1'b1, 8'(n - 3) ^ 8'h55, 1'b0}) begin
          bad++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", n, vid_valid, vid_data, 8'(n - 3) ^ 8'h55);
        end
      end else if (vid_valid !== 1'b0) begin
        bad++; $display("FAIL stream_idle_%0d got=%b exp=0", n, vid_valid);
      end
      vid_req = (n < 16);
      vid_addr = 11'(n);
      #1;
      if (n < 16) begin
        total++;
        if ({vid_gnt, cpu_gnt} !== 2'b10) begin
          bad++; $display("FAIL stream_gnt_%0d got=%b exp=10", n, {vid_gnt, cpu_gnt});
        end
      end
    end
    vid_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic [1:0]  kind [0:12];
    logic [10:0] addr_exp [0:12];
    logic [10:0] vaddr;
    logic        cpu_done;
    vaddr = '0;
    cpu_done = 1'b0;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      if (n >= 3) begin
        total++;
        if ({vid_valid, cpu_rvalid} !== {kind[n-3] == 2'd1, kind[n-3] == 2'd2}) begin
          bad++; $display("FAIL starve_valid_%0d got=%b%b exp=%b%b", n, vid_valid, cpu_rvalid, kind[n-3] == 2'd1, kind[n-3] == 2'd2);
        end
        if (kind[n-3] == 2'd1) begin
          total++;
          if (vid_data !== (addr_exp[n-3][7:0] ^ 8'h55)) begin
            bad++; $display("FAIL starve_vdata_%0d got=%h exp=%h", n, vid_data, addr_exp[n-3][7:0] ^ 8'h55);
          end
        end
        if (kind[n-3] == 2'd2) begin
          total++;
          if (cpu_rdata !== 8'h45) begin
            bad++; $display("FAIL starve_cdata got=%h exp=45", cpu_rdata);
          end
        end
      end
      cpu_req = ~cpu_done; cpu_we = 1'b0; cpu_addr = 11'h010;
      vid_req = (n < 10); vid_addr = vaddr;
      kind[n] = (n >= 10) ? 2'd0 : (n == 4) ? 2'd2 : 2'd1;
      addr_exp[n] = vaddr;
      #1;
      if (n < 10) begin
        total++;
        if ({vid_gnt, cpu_gnt} !== {kind[n] == 2'd1, kind[n] == 2'd2}) begin
          bad++; $display("FAIL starve_gnt_%0d got=%b%b exp=%b%b", n, vid_gnt, cpu_gnt, kind[n] == 2'd1, kind[n] == 2'd2);
        end
      end
      if (kind[n] == 2'd1) vaddr = vaddr + 11'd1;
      if (kind[n] == 2'd2) cpu_done = 1'b1;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 11'h005;
    @(negedge clk);
    vid_req = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_rdata, cpu_rvalid, vid_data, vid_valid, cpu_gnt, vid_gnt} !== '0) begin
      bad++; $display("FAIL mid_reset_zero got=%b%b/%h/%h/%h%b/%h%b/%b%b exp=all0", ram_en, ram_we, ram_addr, ram_wdata, cpu_rdata, cpu_rvalid, vid_data, vid_valid, cpu_gnt, vid_gnt);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      total++;
      if ({vid_valid, cpu_rvalid} !== 2'b00) begin
        bad++; $display("FAIL mid_ghost_%0d got=%b exp=00", n, {vid_valid, cpu_rvalid});
      end
    end
    vid_req = 1'b1; vid_addr = 11'h007;
    #1;
    total++;
    if (vid_gnt !== 1'b1) begin
      bad++; $display("FAIL post_gnt got=%b exp=1", vid_gnt);
    end
    @(negedge clk);
    vid_req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({vid_valid, vid_data} !== {1'b1, 8'h52}) begin
      bad++; $display("FAIL post_read got=%b/%h exp=1/52", vid_valid, vid_data);
    end
  endtask

  task automatic test_raw();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_wdata = 8'h3C;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL raw_cgnt got=%b exp=1", cpu_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    vid_req = 1'b1; vid_addr = 11'h7FF;
    #1;
    total++;
    if (vid_gnt !== 1'b1) begin
      bad++; $display("FAIL raw_vgnt got=%b exp=1", vid_gnt);
    end
    @(negedge clk);
    vid_req = 1'b0;
    @(negedge clk);
    total++;
    if (vid_valid !== 1'b0) begin
      bad++; $display("FAIL raw_early got=%b exp=0", vid_valid);
    end
    @(negedge clk);
    total++;
    if ({vid_valid, vid_data} !== {1'b1, 8'h3C}) begin
      bad++; $display("FAIL raw_data got=%b/%h exp=1/3c", vid_valid, vid_data);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_wr_rd();
    preload();
    test_vid_stream();
    test_starvation();
    test_reset_midflight();
    test_raw();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port 2048x8 video RAM between two requesters: the CPU bus and the character-scanout fetch engine.
- Arbitration uses fixed priority for video, with a starvation guard that forces a CPU slot.
- One RAM access is issued per clock, and read data returns through a 2-stage tagged pipeline.
- Sits between the CPU memory decoder, the text scanout counters and the video RAM array.

Parameters:
- ADDR_W, 11, RAM address width (2048 bytes).
- DATA_W, 8, RAM data width.
- CPU_MAX_STALL, 4, consecutive video-won contested cycles allowed before CPU is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with address/data stable until granted.
- cpu_we  in  1  1=write, 0=read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational; a CPU transfer occurs on any edge where cpu_req&cpu_gnt.
- cpu_rdata  out  DATA_W  CPU read data, registered.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- vid_req  in  1  scanout fetch request (read only).
- vid_addr  in  ADDR_W  scanout address.
- vid_gnt  out  1  combinational; a video transfer occurs on any edge where vid_req&vid_gnt.
- vid_data  out  DATA_W  fetched character code, registered.
- vid_valid  out  1  one-cycle pulse; vid_data valid.
- ram_en  out  1  registered RAM enable.
- ram_we  out  1  registered RAM write enable.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after the RAM samples ram_en=1, ram_we=0.

Behaviour:
- Reset (asynchronous, active-high) clears every registered output and internal state to 0, including:
  - ram_en, ram_we, ram_addr, ram_wdata
  - cpu_rdata, cpu_rvalid, vid_data, vid_valid
  - starvation counter and pipeline tags
- In-flight reads are discarded; no rvalid/valid pulse follows reset release.
- Grants are combinational from request inputs and registered state only; they never depend on ram_rdata.
- Grant rules:
  - Only vid_req: vid_gnt=1.
  - Only cpu_req: cpu_gnt=1.
  - Both requests: video wins unless stall_cnt==CPU_MAX_STALL, in which case CPU wins.
  - At most one grant is high per cycle.
- stall_cnt (4 bits) updates each edge:
  - Clears when cpu_req=0 or a CPU transfer occurs.
  - Increments when cpu_req=1 and video is granted.
  - Saturates at CPU_MAX_STALL.
- Stage 0 (transfer edge E0):
  - Register ram_en=1, ram_we, ram_addr and ram_wdata from the winner.
  - Register tag = {valid, is_cpu, is_read}.
  - With no transfer: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their previous values.
- Stage 1 (edge E1): the RAM samples; the tag advances one stage.
- Stage 2 (edge E2), read tags only:
  - Capture ram_rdata into cpu_rdata or vid_data.
  - Pulse the matching cpu_rvalid or vid_valid for exactly one cycle.
  - Writes produce no response.
- Read latency: valid/rvalid is high in the cycle following E2, i.e. 2 clocks after the transfer edge.
- Throughput: 1 access/clock. Back-to-back transfers from either source produce back-to-back responses in issue order.
- cpu_rdata and vid_data hold their last value between pulses.
- Ordering: requests are executed strictly in grant order. A CPU write granted on cycle N followed by a video read of the same address on N+1 returns the new data.
- Requester changing address or data without a grant: no effect. The arbiter samples only on transfer edges.

Test Plan:
- Reset then idle, no requests → ram_en=0, all valid pulses 0, cpu_gnt=0, vid_gnt=0.
- CPU write addr 0x123 data 0xA5, then CPU read 0x123 → read has cpu_gnt=1, ram_we=1 for one cycle on the write; cpu_rvalid pulses 2 clocks after the read grant with cpu_rdata=0xA5; vid_valid stays 0.
- vid_req held continuously on sequential addresses 0x000..0x00F with RAM preloaded to addr^0x55 → vid_valid high 16 consecutive cycles; vid_data follows 0x55,0x54,… in order, 2-cycle latency.
- vid_req held continuously plus CPU read of 0x010, CPU_MAX_STALL=4 → video granted 4 cycles, CPU granted cycle 5, video resumes cycle 6; cpu_rvalid exactly once, 2 clocks after the CPU grant.
- Assert reset one cycle after a video read grant → no vid_valid pulse after release; all outputs 0 during reset; first post-reset grant behaves normally.
- CPU write 0x7FF=0x3C granted cycle N, video read 0x7FF granted N+1 → vid_data=0x3C at N+3.
